div_unit: RTL and testbench

Iterative RV64M divide/remainder unit in the execute stage. Accepts one DIV/DIVU/REM/REMU (and W-variant) operation per start pulse, computes it with a radix-2 restoring algorithm, and presents a 64-bit result with a one-cycle valid pulse. The result feeds the execute-result select mux as its divide input; the pipeline stalls on `busy`.

---
 rtl/rv64_div_pkg.sv | 28 ++
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 180 ++++++++++++++++++
 tb/tb_div_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv64_div_pkg.sv
// Shared definitions for the RV64M iterative divide unit: op/state encodings,
// architectural widths and a word sign-extension helper.
package rv64_div_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned WLEN = 32;
  localparam int unsigned CntW = 7;

  // funct3[1:0] of the M-extension divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } div_state_e;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{(XLEN - WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration: shift the remainder/quotient pair
// left by one and subtract the divisor, keeping the difference when non-negative.
module div_step #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] quo_i,
  input  logic [Width-1:0] divisor_i,
  output logic [Width-1:0] rem_o,
  output logic [Width-1:0] quo_o
);

  logic [Width:0] trial;
  logic [Width:0] diff;
  logic           fits;

  // One extra bit so the shifted remainder (< 2 * divisor) never overflows
  assign trial = {rem_i, quo_i[Width-1]};
  assign diff  = trial - {1'b0, divisor_i};
  assign fits  = ~diff[Width];

  assign rem_o = fits ? diff[Width-1:0] : trial[Width-1:0];
  assign quo_o = {quo_i[Width-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative RV64M DIV/DIVU/REM/REMU (and W variants) unit. One quotient bit per
// CALC cycle, then a FIX cycle applies signs and selects quotient or remainder.
module div_unit
  import rv64_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic                  word,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] result
);

  if (DATA_WIDTH != XLEN) begin : g_width_check
    $error("div_unit: DATA_WIDTH must be 64");
  end

  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [1:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode for the op being offered on the inputs
  logic            is_signed;
  logic [XLEN-1:0] eff_a, eff_b;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] min_neg;
  logic            div_zero, sgn_ovf;
  logic [XLEN-1:0] spec_sel, spec_res;

  always_comb begin
    is_signed = ~op[0];
    if (word) begin
      eff_a = is_signed ? sext_word(a) : {{(XLEN - WLEN){1'b0}}, a[WLEN-1:0]};
      eff_b = is_signed ? sext_word(b) : {{(XLEN - WLEN){1'b0}}, b[WLEN-1:0]};
      min_neg = {{(XLEN - WLEN + 1){1'b1}}, {(WLEN - 1){1'b0}}};
    end else begin
      eff_a = a;
      eff_b = b;
      min_neg = {1'b1, {(XLEN - 1){1'b0}}};
    end
    sa       = is_signed & eff_a[XLEN-1];
    sb       = is_signed & eff_b[XLEN-1];
    mag_a    = sa ? -eff_a : eff_a;
    mag_b    = sb ? -eff_b : eff_b;
    div_zero = (eff_b == '0);
    sgn_ovf  = is_signed & (eff_a == min_neg) & (eff_b == '1);
    // Zero divisor: q = all-ones, r = dividend. Overflow: q = dividend, r = 0.
    if (op[1]) spec_sel = div_zero ? eff_a : '0;
    else       spec_sel = div_zero ? '1 : eff_a;
    spec_res = word ? sext_word(spec_sel) : spec_sel;
  end

  logic [XLEN-1:0] step_rem, step_quo;

  div_step #(
    .Width(XLEN)
  ) u_div_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(div_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  // Sign fix-up and quotient/remainder select
  logic [XLEN-1:0] q_mag, q_fin, r_fin, fix_sel, fix_res;

  always_comb begin
    q_mag   = word_q ? {{(XLEN - WLEN){1'b0}}, quo_q[WLEN-1:0]} : quo_q;
    q_fin   = qneg_q ? -q_mag : q_mag;
    r_fin   = rneg_q ? -rem_q : rem_q;
    fix_sel = (op_q inside {OP_REM, OP_REMU}) ? r_fin : q_fin;
    fix_res = word_q ? sext_word(fix_sel) : fix_sel;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    op_d     = op_q;
    word_d   = word_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d   = op;
          word_d = word;
          if (div_zero || sgn_ovf) begin
            result_d = spec_res;
            state_d  = StDone;
          end else begin
            qneg_d  = sa ^ sb;
            rneg_d  = sa;
            div_d   = mag_b;
            rem_d   = '0;
            // W ops start with the 32-bit dividend in the upper half so that
            // 32 shifts bring all of it into the remainder.
            quo_d   = word ? {mag_a[WLEN-1:0], {WLEN{1'b0}}} : mag_a;
            cnt_d   = word ? CntW'(WLEN) : CntW'(XLEN);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over everything, including a same-cycle start
    if (flush) begin
      state_d  = StIdle;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      op_q     <= op_d;
      word_q   <= word_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign valid  = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected result and latency are queued at launch
// and compared when valid pulses; also covers flush, stray starts and async reset.
module tb_div_unit;
  import rv64_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        word = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        valid;
  logic [63:0] result;

  always #5 clk = ~clk;

  div_unit #(
    .DATA_WIDTH(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .word  (word),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .valid (valid),
    .result(result)
  );

  typedef struct {
    string       tag;
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last_res = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V divide semantics from SV operators plus the two special cases
  function automatic logic [63:0] ref_div(input logic [1:0] o, input logic w,
                                          input logic [63:0] x, input logic [63:0] y,
                                          output int lat);
    logic        sg;
    logic [63:0] ea, eb, q, r, mn, res;
    sg = ~o[0];
    if (w) begin
      ea = sg ? {{32{x[31]}}, x[31:0]} : {32'b0, x[31:0]};
      eb = sg ? {{32{y[31]}}, y[31:0]} : {32'b0, y[31:0]};
      mn = 64'hFFFF_FFFF_8000_0000;
    end else begin
      ea = x;
      eb = y;
      mn = 64'h8000_0000_0000_0000;
    end
    lat = 1;
    if (eb == 64'd0) begin
      q = '1;
      r = ea;
    end else if (sg && ea == mn && eb == '1) begin
      q = ea;
      r = '0;
    end else begin
      lat = w ? 34 : 66;
      if (sg) begin
        q = $signed(ea) / $signed(eb);
        r = $signed(ea) % $signed(eb);
      end else begin
        q = ea / eb;
        r = ea % eb;
      end
    end
    res = o[1] ? r : q;
    if (w) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  // Drives a one-cycle start; returns at the negedge of cycle 1
  task automatic launch(input string tag, input logic [1:0] o, input logic w,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp_res, input int exp_lat);
    exp_t e;
    @(negedge clk);
    op = o; word = w; a = x; b = y; start = 1'b1;
    e.tag = tag; e.res = exp_res; e.lat = exp_lat;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input int cyc0);
    exp_t e;
    int   cyc;
    cyc = cyc0;
    while (!valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    check_eq({e.tag, "_valid"}, 64'(valid), 64'd1);
    check_eq({e.tag, "_result"}, result, e.res);
    check_eq({e.tag, "_latency"}, 64'(cyc), 64'(e.lat));
    last_res = e.res;
    @(negedge clk);
    check_eq({e.tag, "_pulse"}, {62'd0, valid, busy}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp_res, input int exp_lat);
    launch(tag, o, w, x, y, exp_res, exp_lat);
    collect(1);
  endtask

  task automatic run_ref(input string tag, input logic [1:0] o, input logic w,
                         input logic [63:0] x, input logic [63:0] y);
    logic [63:0] r;
    int          l;
    r = ref_div(o, w, x, y, l);
    run_op(tag, o, w, x, y, r, l);
  endtask

  initial begin
    int          nv;
    logic [63:0] rr;
    int          ll;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {result[61:0], valid, busy}, 64'd0);
    rst_n = 1'b1;

    // Directed cases
    run_op("div_m20_3", 2'(OP_DIV), 1'b0, -64'sd20, 64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
    run_op("rem_m20_3", 2'(OP_REM), 1'b0, -64'sd20, 64'sd3, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run_op("divu_by0", 2'(OP_DIVU), 1'b0, '1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_by0", 2'(OP_REMU), 1'b0, '1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("div_ovf", 2'(OP_DIV), 1'b0, 64'h8000_0000_0000_0000, '1,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", 2'(OP_REM), 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run_op("divuw", 2'(OP_DIVU), 1'b1, 64'h1_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    run_op("remw", 2'(OP_REM), 1'b1, 64'd7, -64'sd2, 64'd1, 34);
    run_op("divw_ovf", 2'(OP_DIV), 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);

    // Start pulses while busy must be ignored
    rr = ref_div(2'(OP_DIV), 1'b0, 64'd1000, -64'sd7, ll);
    launch("stray", 2'(OP_DIV), 1'b0, 64'd1000, -64'sd7, rr, ll);
    a = 64'd5; b = 64'd0; op = 2'(OP_REMU); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    collect(3);

    // Flush in cycle 10 of a divide
    @(negedge clk);
    op = 2'(OP_DIV); word = 1'b0; a = 64'd12345; b = 64'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_busy", 64'(busy), 64'd0);
    check_eq("flush_result", result, last_res);
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    check_eq("flush_novalid", 64'(nv), 64'd0);

    // Flush and start together: start dropped
    op = 2'(OP_DIVU); a = 64'd9; b = 64'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_eq("flush_start_busy", {63'd0, busy}, 64'd0);
    check_eq("flush_start_result", result, last_res);

    run_op("post_flush", 2'(OP_DIV), 1'b0, -64'sd20, 64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);

    // Asynchronous reset in cycle 20
    @(negedge clk);
    op = 2'(OP_DIVU); word = 1'b0; a = '1; b = 64'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("areset_outputs", {result[61:0], valid, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    run_op("post_reset", 2'(OP_DIVU), 1'b0, 64'd100, 64'd7, 64'd14, 66);

    // Random mix against the reference
    for (int i = 0; i < 10; i++) begin
      logic [63:0] x, y;
      logic [1:0]  o;
      logic        w;
      o = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      x = {$urandom, $urandom};
      y = (i % 3 == 0) ? 64'($urandom_range(1, 300)) : {$urandom, $urandom};
      if (i % 4 == 1) x = -x;
      run_ref($sformatf("rand%0d", i), o, w, x, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
